dpram_stream_reader: RTL and testbench

Read-side sequencer for the activation/weight dual-port RAM: on a `start` command it walks `len` consecutive addresses from `base_addr` on one RAM port and turns the registered RAM output into a valid/ready stream of Q5.3 words. It sits directly downstream of the dual-port RAM read port (A or B) and upstream of the systolic-array feeder. It absorbs the RAM's one-cycle read latency with a two-entry skid buffer, so back-pressure never drops or duplicates a word.

---
 rtl/dpram_stream_reader.sv | 139 +++++++++++++
 tb/tb_dpram_stream_reader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dpram_stream_reader.sv
// Read-side sequencer: walks len addresses from base_addr on a RAM read port and
// streams the words through a 2-entry skid FIFO. Optional macro: DPRAM_RD_WRAP_EN.
module dpram_stream_reader #(
    parameter int AWIDTH    = 10,
    parameter int DWIDTH    = 8,
    parameter int NUM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AWIDTH-1:0] ram_addr,
    input  logic [DWIDTH-1:0] ram_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [AWIDTH+1:0] NUM_W = (AWIDTH+2)'(NUM_WORDS);

    state_t            state, state_nxt;
    logic [AWIDTH:0]   len_r, issued;
    logic              inflight, inflight_last;
    logic [DWIDTH-1:0] head_data, tail_data;
    logic              head_last, tail_last;
    logic [1:0]        fifo_count;
    logic [2:0]        occ;
    logic              pop, issue, last_issue, accept, cmd_ok, len_ok;

`ifdef DPRAM_RD_WRAP_EN
    always_comb begin
        len_ok = (len != '0) && ((AWIDTH+2)'(len) <= NUM_W);
        cmd_ok = len_ok;
    end
`else
    logic [AWIDTH+1:0] end_addr;

    always_comb begin
        end_addr = (AWIDTH+2)'(base_addr) + (AWIDTH+2)'(len);
        len_ok   = (len != '0) && ((AWIDTH+2)'(len) <= NUM_W);
        cmd_ok   = len_ok && (end_addr <= NUM_W);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (issue && last_issue) state_nxt = DRAIN;
            DRAIN:   if (pop && head_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Occupancy counts the read already in the RAM pipeline so the FIFO can never overflow.
    always_comb begin
        busy       = (state != IDLE);
        m_valid    = (fifo_count != 2'd0);
        m_data     = head_data;
        m_last     = m_valid && head_last;
        pop        = m_valid && m_ready;
        accept     = (state == IDLE) && start && cmd_ok;
        occ        = 3'(fifo_count) + 3'(inflight) - 3'(pop);
        issue      = (state == RUN) && (occ < 3'd2);
        last_issue = (issued == len_r - (AWIDTH+1)'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done          <= 1'b0;
            err           <= 1'b0;
            ram_addr      <= '0;
            len_r         <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            head_data     <= '0;
            tail_data     <= '0;
            head_last     <= 1'b0;
            tail_last     <= 1'b0;
            fifo_count    <= '0;
        end else begin
            done          <= (state == DRAIN) && pop && head_last;
            err           <= (state == IDLE) && start && !cmd_ok;
            inflight      <= issue;
            inflight_last <= issue && last_issue;
            if (accept) begin
                ram_addr <= base_addr;
                len_r    <= len;
                issued   <= '0;
            end else if (issue) begin
                ram_addr <= ram_addr + 1'b1;
                issued   <= issued + 1'b1;
            end
            case ({inflight, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        head_data <= ram_rdata;
                        head_last <= inflight_last;
                    end else begin
                        tail_data <= ram_rdata;
                        tail_last <= inflight_last;
                    end
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    head_data  <= tail_data;
                    head_last  <= tail_last;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        head_data <= ram_rdata;
                        head_last <= inflight_last;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= ram_rdata;
                        tail_last <= inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Self-checking bench for dpram_stream_reader: directed command table, reset abort
// sequence and random commands checked against a queue-based stream model.
module tb_dpram_stream_reader;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int NW = 1024;
`ifdef DPRAM_RD_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start, m_ready;
    logic [AW-1:0] base_addr, ram_addr;
    logic [AW:0]   len;
    logic          busy, done, err, m_valid, m_last;
    logic [DW-1:0] ram_rdata, m_data;
    logic [DW-1:0] mem [NW];

    int passed = 0;
    int total  = 0;

    dpram_stream_reader #(.AWIDTH(AW), .DWIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .err(err), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= mem[ram_addr];

    typedef struct {
        logic [AW-1:0] base;
        int            len;
        int            mode;     // 0: ready high, 1: ready 1,0,0 repeating, 2: random
        int            restart;  // cycle to pulse start while busy, -1 for none
        bit            exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit model_err(input int b, input int l);
        return (l == 0) || (l > NW) || (!WRAP && (b + l > NW));
    endfunction

    task automatic run_cmd(input logic [AW-1:0] b, input int l, input int mode,
                           input int restart, input bit exp_err);
        logic [DW-1:0] q[$];
        logic [DW-1:0] prev_data;
        bit  prev_stall, done_seen;
        int  beats, first_valid, budget;
        for (int i = 0; i < l && !exp_err; i++) q.push_back(mem[(int'(b) + i) % NW]);
        @(negedge clk);
        start = 1'b1; base_addr = b; len = (AW+1)'(l); m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (exp_err) begin
            check("err_pulse", err, 1'b1);
            check("err_busy", busy, 1'b0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("err_single", err, 1'b0);
                check("err_no_valid", m_valid, 1'b0);
                check("err_idle", busy | done, 1'b0);
            end
            return;
        end
        check("start_no_err", err, 1'b0);
        check("start_busy", busy, 1'b1);
        check("start_addr", ram_addr, b);
        beats = 0; first_valid = -1; prev_stall = 0; done_seen = 0; prev_data = '0;
        budget = l * 4 + 40;
        for (int cyc = 0; cyc < budget && !done_seen; cyc++) begin
            if (prev_stall) begin
                check("stall_valid", m_valid, 1'b1);
                check("stall_data", m_data, prev_data);
            end
            if (err) check("busy_no_err", err, 1'b0);
            if (done) begin
                check("done_all_beats", beats, l);
                check("done_busy_low", busy, 1'b0);
                if (mode == 0) check("done_cycle", cyc, l + 2);
                done_seen = 1;
            end
            if (m_valid && first_valid < 0) begin
                first_valid = cyc;
                if (mode == 0) check("first_latency", cyc, 2);
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (cyc == restart) begin
                start = 1'b1; base_addr = ~b; len = (AW+1)'(1);
            end else begin
                start = 1'b0;
            end
            if (m_valid && m_ready) begin
                if (beats < l) begin
                    check("beat_data", m_data, q[beats]);
                    check("beat_last", m_last, (beats == l - 1));
                end else begin
                    check("extra_beat", beats, l - 1);
                end
                beats++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (!done_seen) @(negedge clk);
        end
        start = 1'b0;
        if (!done_seen) check("done_timeout", 1'b0, 1'b1);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy | m_valid, 1'b0);
    endtask

    initial begin
        vecs[0] = '{base: 10'd5,   len: 4,    mode: 0, restart: -1, exp_err: 1'b0};
        vecs[1] = '{base: 10'd5,   len: 4,    mode: 1, restart: -1, exp_err: 1'b0};
        vecs[2] = '{base: 10'h3FF, len: 1,    mode: 0, restart: -1, exp_err: 1'b0};
        vecs[3] = '{base: 10'h3FE, len: 4,    mode: 0, restart: -1, exp_err: !WRAP};
        vecs[4] = '{base: 10'd0,   len: 0,    mode: 0, restart: -1, exp_err: 1'b1};
        vecs[5] = '{base: 10'd10,  len: 8,    mode: 0, restart: 4,  exp_err: 1'b0};
        vecs[6] = '{base: 10'd0,   len: 1025, mode: 0, restart: -1, exp_err: 1'b1};
        vecs[7] = '{base: 10'd0,   len: 1024, mode: 0, restart: -1, exp_err: 1'b0};
        vecs[8] = '{base: 10'd20,  len: 12,   mode: 2, restart: 3,  exp_err: 1'b0};
        vecs[9] = '{base: 10'd1,   len: 1024, mode: 1, restart: -1, exp_err: !WRAP};

        for (int i = 0; i < NW; i++) mem[i] = DW'($urandom);
        mem[5] = 8'h14; mem[6] = 8'hFC; mem[7] = 8'h19; mem[8] = 8'h08;

        reset = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = '0; len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_valid", m_valid, 1'b0);
        check("rst_last", m_last, 1'b0);
        check("rst_data", m_data, '0);
        check("rst_addr", ram_addr, '0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_cmd(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].restart, vecs[i].exp_err);

        // Abort a 10-word command after three accepted words.
        begin
            int beats = 0;
            @(negedge clk);
            start = 1'b1; base_addr = 10'd100; len = 11'd10; m_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int cyc = 0; cyc < 20 && beats < 3; cyc++) begin
                if (m_valid && m_ready) beats++;
                @(negedge clk);
            end
            check("abort_beats", beats, 3);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("abort_busy", busy, 1'b0);
            check("abort_done", done, 1'b0);
            check("abort_err", err, 1'b0);
            check("abort_valid", m_valid, 1'b0);
            check("abort_last", m_last, 1'b0);
            check("abort_data", m_data, '0);
            check("abort_addr", ram_addr, '0);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check("abort_quiet", done | m_valid | busy, 1'b0);
            end
            run_cmd(10'd200, 6, 0, -1, 1'b0);
        end

        for (int n = 0; n < 20; n++) begin
            int b, l, sel, mode;
            sel  = $urandom_range(0, 9);
            b    = (sel < 5) ? $urandom_range(0, NW - 1) : $urandom_range(990, NW - 1);
            l    = (sel == 0) ? 0 : $urandom_range(1, 40);
            mode = $urandom_range(0, 2);
            run_cmd(AW'(b), l, mode, -1, model_err(b, l));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
